// File: rtl/bitbrick_pkg.sv
// bitbrick_pkg: shared widths, one-hot precision codes, shift constants and width helpers
package bitbrick_pkg;
  localparam int OP_W = 4;
  localparam int BRICK_W = 2;
  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W4 = 3'b100;
  localparam logic [2:0] SH0 = 3'd0;
  localparam logic [2:0] SH2 = 3'd2;
  localparam logic [2:0] SH4 = 3'd4;
  function automatic logic is_legal(input logic [2:0] w);
    return (w == W1) || (w == W2) || (w == W4);
  endfunction
  function automatic logic [2:0] norm_w(input logic [2:0] w);
    return ((w == W1) || (w == W4)) ? w : W2;
  endfunction
endpackage

// File: rtl/bitbrick_decomposer_if.sv
// bitbrick_decomposer_if: operand-pair input (in_*/weight_*/s_valid/s_ready) and brick output (brick_*/err) bundle
interface bitbrick_decomposer_if;
  import bitbrick_pkg::*;
  logic [OP_W-1:0] in_data;
  logic [OP_W-1:0] weight_data;
  logic [2:0] in_width;
  logic [2:0] weight_width;
  logic in_signed;
  logic weight_signed;
  logic s_valid;
  logic s_ready;
  logic [BRICK_W-1:0] brick_x;
  logic [BRICK_W-1:0] brick_y;
  logic brick_x_sign;
  logic brick_y_sign;
  logic [2:0] brick_shift;
  logic brick_valid;
  logic brick_ready;
  logic brick_last;
  logic err;
  modport slave (
    input in_data, weight_data, in_width, weight_width, in_signed, weight_signed, s_valid, brick_ready,
    output s_ready, brick_x, brick_y, brick_x_sign, brick_y_sign, brick_shift, brick_valid, brick_last, err
  );
  modport master (
    output in_data, weight_data, in_width, weight_width, in_signed, weight_signed, s_valid, brick_ready,
    input s_ready, brick_x, brick_y, brick_x_sign, brick_y_sign, brick_shift, brick_valid, brick_last, err
  );
endinterface

// File: rtl/brick_slicer.sv
// brick_slicer: operand data_i, normalized width_i, signed_i, half-select hi_i in; brick_o and its sign_o out
module brick_slicer
  import bitbrick_pkg::*;
(
  input  logic [OP_W-1:0]    data_i,
  input  logic [2:0]         width_i,
  input  logic               signed_i,
  input  logic               hi_i,
  output logic [BRICK_W-1:0] brick_o,
  output logic               sign_o
);
  assign brick_o = (width_i == W1) ? {1'b0, data_i[0]} :
                   (width_i == W4 && hi_i) ? data_i[OP_W-1:BRICK_W] : data_i[BRICK_W-1:0];
  assign sign_o = (width_i == W1) ? 1'b0 : (width_i == W4) ? (hi_i & signed_i) : signed_i;
endmodule

// File: rtl/bitbrick_decomposer.sv
// bitbrick_decomposer: clk/rst plus bus (slave) taking an operand pair and issuing shift-tagged 2-bit brick pairs
module bitbrick_decomposer
  import bitbrick_pkg::*;
(
  input logic clk,
  input logic rst,
  bitbrick_decomposer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0] state_q, state_d;
  logic [OP_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0] xw_q, xw_d, yw_q, yw_d;
  logic xs_q, xs_d, ys_q, ys_d, err_q, err_d;
  logic [1:0] idx_q, idx_d, last_idx;
  logic x4, y4, xhi, yhi, last, xfer, accept;
  assign x4 = xw_q == W4;
  assign y4 = yw_q == W4;
  assign last_idx = (x4 && y4) ? 2'd3 : (x4 || y4) ? 2'd1 : 2'd0;
  assign last = idx_q == last_idx;
  assign bus.brick_valid = state_q == ISSUE;
  assign bus.brick_last = bus.brick_valid && last;
  assign xfer = bus.brick_valid && bus.brick_ready;
  assign bus.s_ready = !rst && ((state_q == IDLE) || (xfer && last));
  assign accept = bus.s_valid && bus.s_ready;
  assign xhi = x4 && idx_q[0];
  assign yhi = y4 && (x4 ? idx_q[1] : idx_q[0]);
  assign bus.brick_shift = (xhi && yhi) ? SH4 : (xhi || yhi) ? SH2 : SH0;
  assign bus.err = err_q;
  always_comb begin
    state_d = accept ? ISSUE : (xfer && last) ? IDLE : state_q;
    idx_d = accept ? 2'd0 : xfer ? idx_q + 2'd1 : idx_q;
    x_d = accept ? bus.in_data : x_q;
    y_d = accept ? bus.weight_data : y_q;
    xw_d = accept ? norm_w(bus.in_width) : xw_q;
    yw_d = accept ? norm_w(bus.weight_width) : yw_q;
    xs_d = accept ? bus.in_signed : xs_q;
    ys_d = accept ? bus.weight_signed : ys_q;
    err_d = accept && !(is_legal(bus.in_width) && is_legal(bus.weight_width));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      xw_q <= '0;
      yw_q <= '0;
      xs_q <= 1'b0;
      ys_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      x_q <= x_d;
      y_q <= y_d;
      xw_q <= xw_d;
      yw_q <= yw_d;
      xs_q <= xs_d;
      ys_q <= ys_d;
      err_q <= err_d;
    end
  end
  brick_slicer u_x (
    .data_i(x_q), .width_i(xw_q), .signed_i(xs_q), .hi_i(xhi),
    .brick_o(bus.brick_x), .sign_o(bus.brick_x_sign)
  );
  brick_slicer u_y (
    .data_i(y_q), .width_i(yw_q), .signed_i(ys_q), .hi_i(yhi),
    .brick_o(bus.brick_y), .sign_o(bus.brick_y_sign)
  );
endmodule

// File: tb/tb_bitbrick_decomposer.sv
// tb_bitbrick_decomposer: directed and randomized checks of brick order, shifts, handshake, err and reset
module tb_bitbrick_decomposer;
  import bitbrick_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bitbrick_decomposer_if bus();
  bitbrick_decomposer dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [1:0] x, y;
    logic xs, ys, last;
    logic [2:0] sh;
    int prod;
  } brick_t;
  brick_t q[$];
  brick_t e;
  int n_chk = 0;
  int n_pass = 0;
  int acc = 0;
  int hold_n = 0;
  bit err_pend = 0;
  bit rnd_rdy = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic bit legal(input logic [2:0] w);
    return w == 3'b001 || w == 3'b010 || w == 3'b100;
  endfunction
  function automatic int opval(input logic [3:0] d, input logic [2:0] w, input logic s);
    if (w == 3'b100) return s ? int'($signed(d)) : int'(d);
    if (w == 3'b001) return int'(d[0]);
    return s ? int'($signed(d[1:0])) : int'(d[1:0]);
  endfunction
  function automatic int bval(input logic [1:0] b, input logic s);
    return s ? int'($signed(b)) : int'(b);
  endfunction
  function automatic void split(input logic [3:0] d, input logic [2:0] w, input logic s,
                                output logic [1:0] v[2], output logic g[2], output int n);
    v[1] = d[3:2];
    g[1] = s;
    n = (w == 3'b100) ? 2 : 1;
    v[0] = (w == 3'b001) ? {1'b0, d[0]} : d[1:0];
    g[0] = (w == 3'b100 || w == 3'b001) ? 1'b0 : s;
  endfunction
  function automatic void push_pair(input logic [3:0] a, input logic [3:0] b, input logic [2:0] aw,
                                    input logic [2:0] bw, input logic as_, input logic bs);
    logic [1:0] xv[2], yv[2];
    logic xg[2], yg[2];
    int nx, ny;
    brick_t t;
    split(a, aw, as_, xv, xg, nx);
    split(b, bw, bs, yv, yg, ny);
    for (int j = 0; j < ny; j++)
      for (int i = 0; i < nx; i++) begin
        t.x = xv[i];
        t.y = yv[j];
        t.xs = xg[i];
        t.ys = yg[j];
        t.sh = 3'(2 * (i + j));
        t.last = (i == nx - 1) && (j == ny - 1);
        t.prod = opval(a, aw, as_) * opval(b, bw, bs);
        q.push_back(t);
      end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", bus.brick_valid, 0);
      check("rst_s_ready", bus.s_ready, 0);
      q.delete();
      err_pend = 0;
      acc = 0;
    end else begin
      check("err", bus.err, err_pend);
      check("valid", bus.brick_valid, q.size() != 0);
      check("s_ready", bus.s_ready, q.size() == 0 || (bus.brick_ready && q[0].last));
      if (q.size() != 0) begin
        e = q[0];
        check("brick_x", bus.brick_x, e.x);
        check("brick_y", bus.brick_y, e.y);
        check("x_sign", bus.brick_x_sign, e.xs);
        check("y_sign", bus.brick_y_sign, e.ys);
        check("shift", bus.brick_shift, e.sh);
        check("last", bus.brick_last, e.last);
        if (bus.brick_ready) begin
          acc += bval(bus.brick_x, bus.brick_x_sign) * bval(bus.brick_y, bus.brick_y_sign) * (1 << bus.brick_shift);
          if (e.last) begin
            check("sum", acc, e.prod);
            acc = 0;
          end
          void'(q.pop_front());
        end
      end
      err_pend = bus.s_valid && bus.s_ready && !(legal(bus.in_width) && legal(bus.weight_width));
      if (bus.s_valid && bus.s_ready)
        push_pair(bus.in_data, bus.weight_data, bus.in_width, bus.weight_width, bus.in_signed, bus.weight_signed);
    end
  end
  initial begin
    bus.brick_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_n > 0) begin
        bus.brick_ready = 1'b0;
        hold_n--;
      end else bus.brick_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] aw,
                      input logic [2:0] bw, input logic as_, input logic bs);
    int t = 0;
    bus.in_data = a;
    bus.weight_data = b;
    bus.in_width = aw;
    bus.weight_width = bw;
    bus.in_signed = as_;
    bus.weight_signed = bs;
    bus.s_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_ready && t < 64);
    if (!bus.s_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    idle(1);
  endtask
  function automatic logic [2:0] rw();
    int r = $urandom_range(0, 7);
    return r < 2 ? W1 : r < 4 ? W2 : r < 7 ? W4 : 3'($urandom_range(0, 7));
  endfunction
  initial begin
    bus.s_valid = 1'b0;
    bus.in_data = '0;
    bus.weight_data = '0;
    bus.in_width = W1;
    bus.weight_width = W1;
    bus.in_signed = 1'b0;
    bus.weight_signed = 1'b0;
    #1;
    check("rst_err", bus.err, 0);
    check("rst_last", bus.brick_last, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    idle(1);
    send(4'b1001, 4'b0101, W4, W4, 1'b1, 1'b1);
    drain();
    send(4'b1011, 4'b1110, W2, W4, 1'b0, 1'b0);
    drain();
    send(4'b0110, 4'b1011, W4, W4, 1'b1, 1'b0);
    hold_n = 3;
    drain();
    send(4'b0011, 4'b1111, W1, W1, 1'b1, 1'b1);
    send(4'b1110, 4'b0001, W1, W1, 1'b1, 1'b1);
    drain();
    send(4'b1110, 4'b0110, 3'b011, W4, 1'b1, 1'b0);
    drain();
    send(4'b1111, 4'b1010, W4, W4, 1'b1, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_valid", bus.brick_valid, 0);
    check("async_last", bus.brick_last, 0);
    #10 rst = 1'b0;
    #1;
    check("post_rst_s_ready", bus.s_ready, 1);
    idle(1);
    send(4'b0111, 4'b1100, W4, W4, 1'b0, 1'b1);
    drain();
    rnd_rdy = 1;
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rw(), rw(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_rdy = 0;
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
